// File: rtl/pharos_snoop_pkg.sv
// pharos_snoop_pkg: shared state type, frame sizing and saturating/popcount helpers
package pharos_snoop_pkg;
    typedef enum logic [1:0] {IDLE, MEASURE, DUMP} state_t;
    localparam int RES_WORD_W = 64;
    localparam int MAX_KEEP_W = 256;
    function automatic int frame_words(input int num_ch);
        return 1 + 3 * num_ch;
    endfunction
    function automatic logic [15:0] keep_popcount(input logic [MAX_KEEP_W-1:0] keep);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) n += 16'(keep[i]);
        return n;
    endfunction
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] s;
        logic [64:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (65'd1 << w) - 65'd1;
        return (s > m) ? m[63:0] : s[63:0];
    endfunction
endpackage

// File: rtl/snoop_channel.sv
// snoop_channel: per-link flit/packet/byte counters and packet-size accumulator
module snoop_channel
    import pharos_snoop_pkg::*;
#(
    parameter int TKEEP_WIDTH = 64,
    parameter int CNT_WIDTH = 48
) (
    input logic clk,
    input logic areset,
    input logic [TKEEP_WIDTH-1:0] keep,
    input logic valid,
    input logic ready,
    input logic last,
    input logic clear,
    input logic count,
    input logic in_measure,
    output logic [CNT_WIDTH-1:0] flits,
    output logic [CNT_WIDTH-1:0] packets,
    output logic [CNT_WIDTH-1:0] bytes,
    output logic [RES_WORD_W-1:0] packet_size,
    output logic packet_size_valid
);
    logic xfer;
    logic [63:0] pc;
    logic [63:0] acc;
    assign xfer = valid & ready;
    assign pc = 64'(keep_popcount(MAX_KEEP_W'(keep)));
    // the accumulator ignores window state so packets spanning windows keep their full size
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            flits <= '0;
            packets <= '0;
            bytes <= '0;
            acc <= '0;
            packet_size <= '0;
            packet_size_valid <= 1'b0;
        end else begin
            packet_size_valid <= xfer && last && in_measure;
            if (xfer) begin
                acc <= last ? '0 : acc + pc;
                if (last) packet_size <= acc + pc;
            end
            if (clear) begin
                flits <= '0;
                packets <= '0;
                bytes <= '0;
            end else if (count && xfer) begin
                flits <= CNT_WIDTH'(sat_add(64'(flits), 64'd1, CNT_WIDTH));
                bytes <= CNT_WIDTH'(sat_add(64'(bytes), pc, CNT_WIDTH));
                if (last) packets <= CNT_WIDTH'(sat_add(64'(packets), 64'd1, CNT_WIDTH));
            end
        end
    end
endmodule

// File: rtl/multi_channel_snooper.sv
// multi_channel_snooper: windowed multi-link traffic counters serialised as one result frame
module multi_channel_snooper
    import pharos_snoop_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int CNT_WIDTH = 48
) (
    input logic clk,
    input logic areset,
    input logic [NUM_CH*TKEEP_WIDTH-1:0] mon_TKEEP,
    input logic [NUM_CH-1:0] mon_TVALID,
    input logic [NUM_CH-1:0] mon_TREADY,
    input logic [NUM_CH-1:0] mon_TLAST,
    input logic measure,
    output logic [RES_WORD_W-1:0] res_TDATA,
    output logic [7:0] res_TKEEP,
    output logic res_TVALID,
    input logic res_TREADY,
    output logic res_TLAST,
    output logic [NUM_CH*RES_WORD_W-1:0] packet_size,
    output logic [NUM_CH-1:0] packet_size_valid,
    output logic measure_sync_out,
    output logic busy
);
    localparam int FW = frame_words(NUM_CH);
    localparam int IW = $clog2(FW);
    state_t state, state_nx;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [CNT_WIDTH-1:0] flits [NUM_CH];
    logic [CNT_WIDTH-1:0] packets [NUM_CH];
    logic [CNT_WIDTH-1:0] bytes [NUM_CH];
    logic [RES_WORD_W-1:0] words [FW];
    logic [IW-1:0] word_idx;
    logic res_valid, clear, count, hs, final_word, measure_d;
    assign clear = (state == IDLE) && measure;
    assign count = (state == MEASURE) && measure;
    assign hs = res_valid && res_TREADY;
    assign final_word = word_idx == IW'(FW - 1);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        snoop_channel #(.TKEEP_WIDTH(TKEEP_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk(clk),
            .areset(areset),
            .keep(mon_TKEEP[c*TKEEP_WIDTH +: TKEEP_WIDTH]),
            .valid(mon_TVALID[c]),
            .ready(mon_TREADY[c]),
            .last(mon_TLAST[c]),
            .clear(clear),
            .count(count),
            .in_measure(state == MEASURE),
            .flits(flits[c]),
            .packets(packets[c]),
            .bytes(bytes[c]),
            .packet_size(packet_size[c*RES_WORD_W +: RES_WORD_W]),
            .packet_size_valid(packet_size_valid[c])
        );
    end
    always_comb begin
        state_nx = clear ? MEASURE :
                   (state == MEASURE && !measure) ? DUMP :
                   (state == DUMP && hs && final_word) ? IDLE : state;
        words[0] = RES_WORD_W'(cycle_cnt);
        for (int c = 0; c < NUM_CH; c++) begin
            words[1+3*c] = RES_WORD_W'(flits[c]);
            words[2+3*c] = RES_WORD_W'(packets[c]);
            words[3+3*c] = RES_WORD_W'(bytes[c]);
        end
    end
    // res_valid is purely registered so res_TREADY never reaches res_TVALID combinationally
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            cycle_cnt <= '0;
            word_idx <= '0;
            res_valid <= 1'b0;
            measure_d <= 1'b0;
        end else begin
            state <= state_nx;
            measure_d <= measure;
            res_valid <= (state == DUMP) && !(hs && final_word);
            if (clear) cycle_cnt <= '0;
            else if (count) cycle_cnt <= CNT_WIDTH'(sat_add(64'(cycle_cnt), 64'd1, CNT_WIDTH));
            if (clear) word_idx <= '0;
            else if (hs) word_idx <= final_word ? '0 : word_idx + IW'(1);
        end
    end
    assign res_TDATA = words[word_idx];
    assign res_TKEEP = res_valid ? 8'hFF : 8'h00;
    assign res_TVALID = res_valid;
    assign res_TLAST = res_valid && final_word;
    assign measure_sync_out = measure_d;
    assign busy = state != IDLE;
endmodule
